// File: rtl/juego_pkg.sv
// Shared state codes and widths for the flappy-bird game-state controller.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package juego_pkg;

    // State codes are visible on the `state` port, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READY     = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_HIT       = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_e;

    localparam int LIVES_W = 4;

    // Largest of the three phase lengths; sizes the shared frame timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fsm_juego_param_tick_timer.sv
// Frame-tick counter with synchronous clear and a terminal-count strobe.
// Latency: done is combinational from cnt/en/term; cnt updates one cycle after en.
// Backpressure: none; clr wins over en, and en is sampled every cycle.
module tick_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic          done
);

    logic [CW-1:0] cnt;

    // Count ticks; the owner clears on every state change, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done = en && (cnt == term);

endmodule

// File: rtl/fsm_juego_param.sv
// Game-state controller: lives, READY countdown, HIT respawn and GAME_OVER phases.
// Latency: one cycle from input to state/Moore outputs; start_p/hit_p registered.
// Backpressure: none; all inputs are sampled every cycle, tick paces timed phases.
module fsm_juego_param
    import juego_pkg::*;
#(
    parameter int NUM_LIVES   = 3,
    parameter int READY_TICKS = 90,
    parameter int HIT_TICKS   = 60,
    parameter int OVER_TICKS  = 180,
    parameter int CW          = $clog2(max3(READY_TICKS, HIT_TICKS, OVER_TICKS) + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               jump,
    input  logic               pausa,
    input  logic               looser,
    output logic               en_pausa,
    output logic               en_counter,
    output logic               game_over,
    output logic [LIVES_W-1:0] lives,
    output logic [2:0]         state,
    output logic               start_p,
    output logic               hit_p
);

    localparam logic [CW-1:0]      READY_TERM = CW'(READY_TICKS - 1);
    localparam logic [CW-1:0]      HIT_TERM   = CW'(HIT_TICKS - 1);
    localparam logic [CW-1:0]      OVER_TERM  = CW'(OVER_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);

    state_e        st_q;
    state_e        st_d;
    logic [CW-1:0] tmr_term;
    logic          tmr_en;
    logic          tmr_clr;
    logic          tmr_done;
    logic          start_d;
    logic          hit_d;

    // Timer terminal value and enable follow the registered state only.
    always_comb begin
        tmr_term = '0;
        tmr_en   = 1'b0;
        case (st_q)
            ST_READY:     begin tmr_term = READY_TERM; tmr_en = tick; end
            ST_HIT:       begin tmr_term = HIT_TERM;   tmr_en = tick; end
            ST_GAME_OVER: begin tmr_term = OVER_TERM;  tmr_en = tick; end
            default:      ;
        endcase
    end

    tick_timer #(
        .CW (CW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .term (tmr_term),
        .done (tmr_done)
    );

    // Next-state decode; pausa beats looser in PLAYING so a paused hit costs nothing.
    always_comb begin
        st_d    = st_q;
        start_d = 1'b0;
        hit_d   = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (jump && !pausa) begin
                    st_d    = ST_READY;
                    start_d = 1'b1;
                end
            end
            ST_READY: begin
                if (tmr_done) st_d = ST_PLAYING;
            end
            ST_PLAYING: begin
                if (pausa) begin
                    st_d = ST_PAUSED;
                end else if (looser) begin
                    hit_d = 1'b1;
                    st_d  = (lives == LIVES_W'(1)) ? ST_GAME_OVER : ST_HIT;
                end
            end
            ST_PAUSED: begin
                if (jump && !pausa) st_d = ST_READY;
            end
            ST_HIT: begin
                if (tmr_done) st_d = ST_READY;
            end
            ST_GAME_OVER: begin
                if (tmr_done) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
        // Clearing on the transition edge drops any tick coincident with entry.
        tmr_clr = (st_d != st_q);
    end

    // State, lives and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            lives   <= LIVES_INIT;
            start_p <= 1'b0;
            hit_p   <= 1'b0;
        end else begin
            st_q    <= st_d;
            start_p <= start_d;
            hit_p   <= hit_d;
            if (start_d) begin
                lives <= LIVES_INIT;
            end else if (hit_d) begin
                lives <= lives - LIVES_W'(1);
            end
        end
    end

    assign state      = st_q;
    assign en_pausa   = (st_q != ST_PLAYING);
    assign en_counter = (st_q == ST_HIT) || (st_q == ST_GAME_OVER);
    assign game_over  = (st_q == ST_GAME_OVER);

endmodule

// File: tb/tb_fsm_juego_param.sv
// Bench for fsm_juego_param: directed table, hand corner sequences, random run vs model.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_fsm_juego_param;

    localparam int A_NL = 3, A_RT = 3, A_HT = 2, A_OT = 4;
    localparam int B_NL = 2, B_RT = 1, B_HT = 1, B_OT = 1;

    logic clk = 1'b0;
    logic rst, tick, jump, pausa, looser;

    logic       a_en_pausa, a_en_counter, a_game_over, a_start_p, a_hit_p;
    logic [3:0] a_lives;
    logic [2:0] a_state;
    logic       b_en_pausa, b_en_counter, b_game_over, b_start_p, b_hit_p;
    logic [3:0] b_lives;
    logic [2:0] b_state;

    always #5 clk = ~clk;

    fsm_juego_param #(
        .NUM_LIVES(A_NL), .READY_TICKS(A_RT), .HIT_TICKS(A_HT), .OVER_TICKS(A_OT)
    ) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .jump(jump), .pausa(pausa), .looser(looser),
        .en_pausa(a_en_pausa), .en_counter(a_en_counter), .game_over(a_game_over),
        .lives(a_lives), .state(a_state), .start_p(a_start_p), .hit_p(a_hit_p)
    );

    fsm_juego_param #(
        .NUM_LIVES(B_NL), .READY_TICKS(B_RT), .HIT_TICKS(B_HT), .OVER_TICKS(B_OT)
    ) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .jump(jump), .pausa(pausa), .looser(looser),
        .en_pausa(b_en_pausa), .en_counter(b_en_counter), .game_over(b_game_over),
        .lives(b_lives), .state(b_state), .start_p(b_start_p), .hit_p(b_hit_p)
    );

    // Reference: phase number, lives, and ticks still owed before the phase ends.
    typedef struct {
        int st;
        int lives;
        int left;
        bit sp;
        bit hp;
    } mdl_t;

    typedef struct {
        bit r, tk, j, p, l;
        int st;
        int lv;
        bit sp;
        bit hp;
    } vec_t;

    mdl_t ma, mb;
    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   printed  = 0;

    function automatic mdl_t mstep(input mdl_t m, input bit r, input bit tk, input bit j,
                                   input bit p, input bit l,
                                   input int nl, input int rt, input int ht, input int ot);
        mdl_t n;
        n    = m;
        n.sp = 1'b0;
        n.hp = 1'b0;
        if (r) begin
            n.st = 0; n.lives = nl; n.left = 0;
            return n;
        end
        case (m.st)
            0: if (j && !p) begin n.st = 1; n.lives = nl; n.left = rt; n.sp = 1'b1; end
            1: if (tk) begin
                   if (m.left == 1) n.st = 2; else n.left = m.left - 1;
               end
            2: if (p) n.st = 3;
               else if (l) begin
                   n.lives = m.lives - 1;
                   n.hp    = 1'b1;
                   if (m.lives == 1) begin n.st = 5; n.left = ot; end
                   else begin n.st = 4; n.left = ht; end
               end
            3: if (j && !p) begin n.st = 1; n.left = rt; end
            4: if (tk) begin
                   if (m.left == 1) begin n.st = 1; n.left = rt; end
                   else n.left = m.left - 1;
               end
            5: if (tk) begin
                   if (m.left == 1) n.st = 0; else n.left = m.left - 1;
               end
            default: n.st = 0;
        endcase
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (printed < 30) begin
                printed++;
                $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
            end
        end
    endtask

    task automatic chk_dut(input string tag, input mdl_t m, input logic [2:0] st,
                           input logic [3:0] lv, input logic ep, input logic ec,
                           input logic go, input logic sp, input logic hp);
        chk({tag, ".state"},      st, m.st);
        chk({tag, ".lives"},      lv, m.lives);
        chk({tag, ".en_pausa"},   ep, (m.st != 2) ? 1 : 0);
        chk({tag, ".en_counter"}, ec, (m.st == 4 || m.st == 5) ? 1 : 0);
        chk({tag, ".game_over"},  go, (m.st == 5) ? 1 : 0);
        chk({tag, ".start_p"},    sp, m.sp ? 1 : 0);
        chk({tag, ".hit_p"},      hp, m.hp ? 1 : 0);
    endtask

    task automatic step(input bit r, input bit tk, input bit j, input bit p, input bit l);
        rst = r; tick = tk; jump = j; pausa = p; looser = l;
        @(posedge clk);
        ma = mstep(ma, r, tk, j, p, l, A_NL, A_RT, A_HT, A_OT);
        mb = mstep(mb, r, tk, j, p, l, B_NL, B_RT, B_HT, B_OT);
        #1;
        chk_dut("A", ma, a_state, a_lives, a_en_pausa, a_en_counter, a_game_over, a_start_p, a_hit_p);
        chk_dut("B", mb, b_state, b_lives, b_en_pausa, b_en_counter, b_game_over, b_start_p, b_hit_p);
    endtask

    function automatic vec_t mk(input bit r, input bit tk, input bit j, input bit p, input bit l,
                                input int st, input int lv, input bit sp, input bit hp);
        vec_t v;
        v.r = r; v.tk = tk; v.j = j; v.p = p; v.l = l;
        v.st = st; v.lv = lv; v.sp = sp; v.hp = hp;
        return v;
    endfunction

    initial begin
        rst = 1'b1; tick = 1'b0; jump = 1'b0; pausa = 1'b0; looser = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};

        // Directed walk for instance A (3 lives, READY=3, HIT=2, OVER=4).
        //                r  tk j  p  l   st lv sp hp
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 3, 0, 0)); // reset
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 3, 0, 0)); // tick ignored in IDLE
        tbl.push_back(mk(0, 0, 1, 1, 0,  0, 3, 0, 0)); // jump blocked by pausa
        tbl.push_back(mk(0, 1, 1, 0, 0,  1, 3, 1, 0)); // start; entry tick dropped
        tbl.push_back(mk(0, 1, 1, 0, 0,  1, 3, 0, 0)); // tick 1, jump held
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 3, 0, 0)); // pausa ignored in READY
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 3, 0, 0)); // tick 2
        tbl.push_back(mk(0, 1, 0, 0, 0,  2, 3, 0, 0)); // tick 3 -> PLAYING
        tbl.push_back(mk(0, 0, 0, 1, 1,  3, 3, 0, 0)); // pausa beats looser
        tbl.push_back(mk(0, 0, 1, 1, 0,  3, 3, 0, 0)); // still paused
        tbl.push_back(mk(0, 0, 1, 0, 0,  1, 3, 0, 0)); // resume -> READY
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  2, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  4, 2, 0, 1)); // first hit
        tbl.push_back(mk(0, 1, 0, 1, 1,  4, 2, 0, 0)); // HIT tick 1, inputs ignored
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2, 0, 0)); // HIT tick 2 -> READY
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  2, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  4, 1, 0, 1)); // second hit
        tbl.push_back(mk(0, 1, 0, 0, 0,  4, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  5, 0, 0, 1)); // last life -> GAME_OVER
        tbl.push_back(mk(0, 1, 1, 0, 1,  5, 0, 0, 0)); // inputs ignored
        tbl.push_back(mk(0, 1, 0, 0, 0,  5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0)); // 4th tick -> IDLE, lives stay 0
        tbl.push_back(mk(0, 0, 1, 0, 0,  1, 3, 1, 0)); // new game reloads lives
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  2, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  4, 2, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0,  4, 2, 0, 0)); // timer mid-count
        tbl.push_back(mk(1, 1, 1, 0, 1,  0, 3, 0, 0)); // reset overrides all
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 3, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].tk, tbl[i].j, tbl[i].p, tbl[i].l);
            chk($sformatf("tbl[%0d].state", i), a_state, tbl[i].st);
            chk($sformatf("tbl[%0d].lives", i), a_lives, tbl[i].lv);
            chk($sformatf("tbl[%0d].start_p", i), a_start_p, tbl[i].sp ? 1 : 0);
            chk($sformatf("tbl[%0d].hit_p", i), a_hit_p, tbl[i].hp ? 1 : 0);
        end

        // Instance B: every phase lasts one tick; entry-cycle ticks must not count.
        step(1, 0, 0, 0, 0);
        chk("b_seq.reset_lives", b_lives, 2);
        step(0, 1, 1, 0, 0);
        chk("b_seq.ready_entry", b_state, 1);
        step(0, 1, 0, 0, 0);
        chk("b_seq.ready_exit", b_state, 2);
        step(0, 1, 0, 0, 1);
        chk("b_seq.hit_entry", b_state, 4);
        chk("b_seq.hit_lives", b_lives, 1);
        step(0, 1, 0, 0, 0);
        chk("b_seq.hit_exit", b_state, 1);
        step(0, 0, 0, 0, 0);
        chk("b_seq.ready_hold", b_state, 1);
        step(0, 1, 0, 0, 0);
        chk("b_seq.ready_exit2", b_state, 2);
        step(0, 0, 0, 0, 1);
        chk("b_seq.over_entry", b_state, 5);
        chk("b_seq.over_lives", b_lives, 0);
        step(0, 1, 0, 0, 0);
        chk("b_seq.over_exit", b_state, 0);

        // Random traffic against the model for both parameter sets.
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_juego_param.md
# fsm_juego_param

Parametrised game-state controller for the flappy-bird datapath, the next generation of the pause/playing/lose controller. Adds a lives counter, a pre-play READY countdown, distinct HIT (life lost, respawn) and GAME_OVER phases, and an internal frame-tick timer that replaces the external `time_out` input. It sits between the button/collision logic and the scroll, score and display units. It keeps the `en_pausa`/`en_counter` contract so downstream blocks are unchanged.

## Interface
Parameters:
- `NUM_LIVES`, default 3: lives loaded at game start; range 1–15.
- `READY_TICKS`, default 90: frame ticks spent in READY before PLAYING; ≥1.
- `HIT_TICKS`, default 60: frame ticks spent in HIT; ≥1.
- `OVER_TICKS`, default 180: frame ticks spent in GAME_OVER; ≥1.
- `CW`, default derived: timer width, `$clog2` of max(READY_TICKS, HIT_TICKS, OVER_TICKS)+1.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: one-cycle frame strobe; the timer advances only on `tick`.
- `jump` in 1: jump button, already debounced, level.
- `pausa` in 1: pause switch, level.
- `looser` in 1: collision detected, level.
- `en_pausa` out 1: freeze the world; 1 in every state except PLAYING.
- `en_counter` out 1: enable the lose-animation counter; 1 in HIT and GAME_OVER.
- `game_over` out 1: 1 in GAME_OVER.
- `lives` out 4: remaining lives.
- `state` out 3: current state code, for display and debug.
- `start_p` out 1: one-cycle pulse when a new game starts.
- `hit_p` out 1: one-cycle pulse when a life is lost.

## Operation
- State codes: IDLE=0, READY=1, PLAYING=2, PAUSED=3, HIT=4, GAME_OVER=5. Codes 6–7 are illegal and go to IDLE on the next clock.
- IDLE: if `jump & !pausa`, go to READY, load `lives`=NUM_LIVES and assert `start_p`.
- READY: `pausa` is ignored. Go to PLAYING on the cycle where `tick` is high and the timer equals READY_TICKS-1.
- PLAYING:
  - `pausa` has priority: go to PAUSED.
  - Otherwise, if `looser` is high, decrement `lives` and assert `hit_p`. If `lives` was 1, go to GAME_OVER (lives becomes 0); otherwise go to HIT.
- PAUSED: if `jump & !pausa`, go to READY; the countdown replays. `lives` is retained.
- HIT: `looser` and `pausa` are ignored. Go to READY when `tick` is high and the timer equals HIT_TICKS-1.
- GAME_OVER: inputs are ignored. Go to IDLE when `tick` is high and the timer equals OVER_TICKS-1. `lives` stays 0 until the next game start.
- Timer:
  - Clears to 0 on every state change.
  - Increments on `tick` in READY, HIT and GAME_OVER.
  - Holds in the other states.
  - Never wraps: the exit condition always fires at terminal count.
- Outputs `en_pausa`, `en_counter`, `game_over` and `state` are Moore outputs, decoded combinationally from the registered state.

## Timing
- Reset values: state=IDLE, `lives`=NUM_LIVES, timer=0, `en_pausa`=1, `en_counter`=0, `game_over`=0, `start_p`=0, `hit_p`=0.
- `rst` mid-game returns to IDLE on the next edge and overrides all other inputs.
- Each transition takes effect on the clock edge that samples the condition. Moore outputs change in that same cycle, with one cycle of latency from the input.
- `start_p` and `hit_p` are registered. Each is high exactly in the first cycle of the new state, for one cycle.
- A state with parameter N ticks lasts exactly N `tick` strobes. With N=1 it exits on the first tick after entry.
- A `tick` arriving in the same cycle as state entry is not counted, because the timer is being cleared.
- `pausa` and `looser` high together in PLAYING: go to PAUSED, with no life lost.
- `jump` held continuously: IDLE→READY occurs once. Nothing fires in READY, HIT or GAME_OVER.

## Structure
- Package `juego_pkg`: state-code localparams (3-bit) and a lives-width constant (4).
- Sub-module `tick_timer`: CW-bit counter with `clr`, `en`=tick, a terminal value input, and a `done` output (`en & cnt==term`). It is instantiated once; the FSM muxes the terminal value by state.
- The FSM register, `lives` register and pulse registers live in the top module.

## Test plan
- Reset, then `jump`, with READY_TICKS=3: `start_p` for 1 cycle, `lives`=3, state 1. After the 3rd `tick`, state 2 and `en_pausa`=0.
- In PLAYING, pulse `looser` with NUM_LIVES=3: `hit_p`, `lives`=2, state 4, `en_counter`=1. After HIT_TICKS ticks, state 1, then state 2.
- Three collisions: the third goes to state 5 with `game_over`=1 and `lives`=0. After OVER_TICKS ticks, state 0, `en_pausa`=1, `en_counter`=0.
- `pausa` and `looser` in the same cycle in PLAYING: state 3, `lives` unchanged, no `hit_p`. Release `pausa` and press `jump`: state 1.
- Assert `rst` in HIT with timer mid-count: next cycle state 0, `lives`=NUM_LIVES, all outputs at reset values.
- With all tick parameters =1: every timed state exits on the first `tick`. Confirm that a `tick` in the entry cycle is not counted.
